// File: rtl/plic_claim_arb_pkg.sv
// Shared defaults and types for the PLIC claim/complete arbiter.
// Candidate struct widths follow the package defaults.
package plic_pkg;

    localparam int PLIC_IRQ_NUM    = 32;
    localparam int PLIC_PRIO_WIDTH = 3;
    localparam int PLIC_ID_WIDTH   = $clog2(PLIC_IRQ_NUM);

    typedef enum logic {
        ARB_SCAN,
        ARB_LATCH
    } arb_state_e;

    typedef struct packed {
        logic [PLIC_ID_WIDTH-1:0]   id;
        logic [PLIC_PRIO_WIDTH-1:0] prio;
    } plic_cand_t;

endpackage

// File: rtl/plic_claim_arb_if.sv
// Claim/complete access port between the APB register file and the arbiter.
// master = register file side, slave = arbiter side.
interface plic_claim_arb_if
    import plic_pkg::*;
#(
    parameter int IRQ_NUM  = PLIC_IRQ_NUM,
    parameter int ID_WIDTH = $clog2(IRQ_NUM)
);

    logic                claim_i;
    logic                comp_i;
    logic [ID_WIDTH-1:0] comp_id_i;
    logic [ID_WIDTH-1:0] claim_id_o;
    logic [IRQ_NUM-1:0]  ip_clr_o;

    modport master (
        output claim_i, comp_i, comp_id_i,
        input  claim_id_o, ip_clr_o
    );

    modport slave (
        input  claim_i, comp_i, comp_id_i,
        output claim_id_o, ip_clr_o
    );

endinterface

// File: rtl/plic_claim_arb_prio_cmp.sv
// Eligibility check plus strict-greater priority compare of one source
// against the running candidate; ties keep the earlier (lower) ID.
module plic_prio_cmp
    import plic_pkg::*;
(
    input  logic [PLIC_ID_WIDTH-1:0]   idx,
    input  logic                       pend,
    input  logic                       en,
    input  logic                       busy,
    input  logic [PLIC_PRIO_WIDTH-1:0] prio,
    input  plic_cand_t                 cand,
    output plic_cand_t                 cand_nxt
);

    logic elig;

    assign elig = pend & en & ~busy & (prio != '0);

    always_comb begin
        cand_nxt = cand;
        if (elig && (prio > cand.prio)) begin
            cand_nxt.id   = idx;
            cand_nxt.prio = prio;
        end
    end

endmodule

// File: rtl/plic_claim_arb.sv
// PLIC target-context claim/complete arbiter with a one-source-per-cycle sweep.
// Define PLIC_ARB_INSERV_EN to enable the in-service mask and complete writes.
module plic_claim_arb
    import plic_pkg::*;
#(
    parameter int IRQ_NUM    = PLIC_IRQ_NUM,
    parameter int PRIO_WIDTH = PLIC_PRIO_WIDTH,
    parameter int ID_WIDTH   = $clog2(IRQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [IRQ_NUM-1:0]            ip_i,
    input  logic [IRQ_NUM-1:0]            ie_i,
    input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
    input  logic [PRIO_WIDTH-1:0]         thold_i,
    plic_claim_arb_if.slave               bus,
    output logic                          irq_o
);

    localparam logic [ID_WIDTH-1:0] FIRST_ID = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(IRQ_NUM-1);
    localparam logic [IRQ_NUM-1:0]  ONE_HOT  = {{(IRQ_NUM-1){1'b0}}, 1'b1};

    arb_state_e          state;
    logic [ID_WIDTH-1:0] idx;
    plic_cand_t          cand;
    plic_cand_t          cand_nxt;
    plic_cand_t          res;
    logic [IRQ_NUM-1:0]  inserv;
    logic [IRQ_NUM-1:0]  ip_clr;
    logic [ID_WIDTH-1:0] claim_id;
    logic                claim_hit;

    plic_prio_cmp u_cmp (
        .idx      (idx),
        .pend     (ip_i[idx]),
        .en       (ie_i[idx]),
        .busy     (inserv[idx]),
        .prio     (prio_i[idx*PRIO_WIDTH +: PRIO_WIDTH]),
        .cand     (cand),
        .cand_nxt (cand_nxt)
    );

    // Re-check the latched winner so a source dropped mid-sweep reads as 0.
    assign claim_id = (ip_i[res.id] && ie_i[res.id] && !inserv[res.id])
                    ? res.id : '0;
    assign claim_hit = bus.claim_i && (claim_id != '0);

    assign bus.claim_id_o = claim_id;
    assign bus.ip_clr_o   = ip_clr;

`ifdef PLIC_ARB_INSERV_EN
    logic comp_ok;

    assign comp_ok = bus.comp_i
                  && (bus.comp_id_i != '0)
                  && ({1'b0, bus.comp_id_i} <= (ID_WIDTH+1)'(IRQ_NUM-1))
                  && inserv[bus.comp_id_i];

    // Claim is applied last so a same-ID claim+complete leaves it set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inserv <= '0;
        end else begin
            if (comp_ok)   inserv[bus.comp_id_i] <= 1'b0;
            if (claim_hit) inserv[claim_id]      <= 1'b1;
        end
    end
`else
    logic comp_unused;

    assign comp_unused = bus.comp_i ^ (^bus.comp_id_i);
    assign inserv      = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ARB_SCAN;
            idx    <= FIRST_ID;
            cand   <= '0;
            res    <= '0;
            irq_o  <= 1'b0;
            ip_clr <= '0;
        end else begin
            ip_clr <= '0;
            if (claim_hit) begin
                ip_clr <= ONE_HOT << claim_id;
                res    <= '0;
                irq_o  <= 1'b0;
                cand   <= '0;
                idx    <= FIRST_ID;
                state  <= ARB_SCAN;
            end else begin
                unique case (state)
                    ARB_SCAN: begin
                        cand <= cand_nxt;
                        if (idx == LAST_ID) state <= ARB_LATCH;
                        else                idx   <= idx + 1'b1;
                    end
                    ARB_LATCH: begin
                        res   <= cand;
                        cand  <= '0;
                        idx   <= FIRST_ID;
                        irq_o <= (cand.prio > thold_i);
                        state <= ARB_SCAN;
                    end
                    default: state <= ARB_SCAN;
                endcase
            end
        end
    end

endmodule
